// File: rtl/offset_cal_accum.sv
// Offset calibration: discards SETTLE settling samples, averages 2^LOG2N shorted-input
// samples and publishes the rounded mean as a registered offset estimate.
module offset_cal_accum #(
  parameter int unsigned W      = 24,
  parameter int unsigned LOG2N  = 8,
  parameter int unsigned SETTLE = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic                in_valid,
  input  logic signed [W-1:0] din,
  output logic signed [W-1:0] offset,
  output logic                offset_valid,
  output logic                busy,
  output logic                done
);

  localparam int unsigned N    = 32'(1) << LOG2N;
  localparam int unsigned AW   = W + LOG2N;
  localparam int unsigned MAXC = (SETTLE > N) ? SETTLE : N;
  localparam int unsigned CW   = $clog2(MAXC + 1);

  localparam logic [CW-1:0]        SETTLE_LAST = CW'(SETTLE - 1);
  localparam logic [CW-1:0]        N_LAST      = CW'(N - 1);
  // Half an LSB of the averaged result, for round-half-up
  localparam logic signed [AW-1:0] RND         = (LOG2N == 0) ? '0 : AW'(N >> 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_ACCUM  = 2'd2,
    S_UPDATE = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic signed [AW-1:0]  acc_q, acc_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic signed [W-1:0]   offset_q, offset_d;
  logic                  valid_q, valid_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic signed [AW-1:0]  rnd_sum;

  assign rnd_sum = acc_q + RND;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; abort wins over every other transition
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          state_d = (SETTLE == 0) ? S_ACCUM : S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (in_valid && (cnt_q == SETTLE_LAST)) begin
          state_d = S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (in_valid && (cnt_q == N_LAST)) begin
          state_d = S_UPDATE;
        end
      end
      S_UPDATE: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Datapath and output next values
  always_comb begin
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    offset_d = offset_q;
    valid_d  = valid_q;
    done_d   = 1'b0;
    busy_d   = (state_d != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          acc_d = '0;
          cnt_d = '0;
        end
      end
      S_SETTLE: begin
        if (!abort && in_valid) begin
          cnt_d = (cnt_q == SETTLE_LAST) ? '0 : cnt_q + CW'(1);
        end
      end
      S_ACCUM: begin
        if (!abort && in_valid) begin
          acc_d = acc_q + AW'(din);
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_UPDATE: begin
        if (!abort) begin
          offset_d = W'(rnd_sum >>> LOG2N);
          valid_d  = 1'b1;
          done_d   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      cnt_q    <= '0;
      offset_q <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      offset_q <= offset_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign offset       = offset_q;
  assign offset_valid = valid_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_offset_cal_accum.sv
// Randomized bench for offset_cal_accum against a run-level average model.
module tb_offset_cal_accum;

  localparam int W      = 24;
  localparam int LOG2N  = 8;
  localparam int SETTLE = 16;
  localparam int N      = 256;

  localparam logic signed [W-1:0] Z = '0;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                start;
  logic                abort;
  logic                in_valid;
  logic signed [W-1:0] din;
  logic signed [W-1:0] offset;
  logic                offset_valid;
  logic                busy;
  logic                done;

  always #5 clk = ~clk;

  offset_cal_accum #(.W(W), .LOG2N(LOG2N), .SETTLE(SETTLE)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .in_valid    (in_valid),
    .din         (din),
    .offset      (offset),
    .offset_valid(offset_valid),
    .busy        (busy),
    .done        (done)
  );

  int n_chk = 0;
  int n_pass = 0;
  int done_cnt = 0;

  // Model: a run is "how many samples accepted so far" plus their post-settle sum
  bit                  m_run, m_pend, m_valid, m_done;
  int                  m_cnt;
  longint              m_sum;
  logic signed [W-1:0] m_off;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // Mean rounded half toward +inf using floor division
  function automatic longint rnd_avg(input longint s);
    longint q;
    q = s + longint'(N / 2);
    if (q >= 0) return q / N;
    return -((-q + N - 1) / N);
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_run = 0; m_pend = 0; m_valid = 0; m_done = 0;
        m_cnt = 0; m_sum = 0; m_off = '0;
      end else begin
        m_done = 0;
        if (m_pend) begin
          m_pend = 0;
          if (!abort) begin
            m_off   = W'(rnd_avg(m_sum));
            m_valid = 1;
            m_done  = 1;
          end
        end else if (m_run) begin
          if (abort) m_run = 0;
          else if (in_valid) begin
            m_cnt++;
            if (m_cnt > SETTLE) m_sum += longint'(din);
            if (m_cnt == SETTLE + N) begin
              m_run  = 0;
              m_pend = 1;
            end
          end
        end else if (start && !abort) begin
          m_run = 1;
          m_cnt = 0;
          m_sum = 0;
        end
      end
    end
  end

  // Per-cycle comparison against the model
  initial begin
    forever begin
      @(negedge clk);
      chk("offset", longint'(offset), longint'(m_off));
      chk("offset_valid", longint'(offset_valid), longint'(m_valid));
      chk("done", longint'(done), longint'(m_done));
      chk("busy", longint'(busy), longint'(m_run || m_pend));
      if (done) done_cnt++;
    end
  end

  task automatic cyc(input bit s, input bit a, input bit v, input logic signed [W-1:0] d);
    start = s; abort = a; in_valid = v; din = d;
    @(posedge clk);
    #2;
  endtask

  function automatic logic signed [W-1:0] smp(input int kind, input int i);
    logic signed [W-1:0] v;
    case (kind)
      0:       v = W'(999);
      1:       v = W'(100);
      2:       v = W'(i % 2);
      3:       v = (i < 128) ? W'(-1) : W'(0);
      4:       v = W'(-8388608);
      5:       v = W'(8388607);
      6:       v = W'(5);
      default: v = W'($urandom);
    endcase
    return v;
  endfunction

  // gap: 0 back-to-back, 1 alternate with start pulses on idle cycles, 2 random gaps
  task automatic feed(input int n, input int kind, input int gap);
    for (int i = 0; i < n; i++) begin
      if (gap == 1) cyc(1'b1, 1'b0, 1'b0, W'($urandom));
      else if (gap == 2) repeat ($urandom_range(2)) cyc(1'b0, 1'b0, 1'b0, W'($urandom));
      cyc(1'b0, 1'b0, 1'b1, smp(kind, i));
    end
  endtask

  task automatic run(input int kind, input int gap);
    cyc(1'b1, 1'b0, 1'b0, Z);
    feed(SETTLE, 0, gap);
    feed(N, kind, gap);
    cyc(1'b0, 1'b0, 1'b0, Z);
    cyc(1'b0, 1'b0, 1'b0, Z);
  endtask

  initial begin
    int dc;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; in_valid = 1'b0; din = Z;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_offset", longint'(offset), 0);
    chk("rst_valid", longint'(offset_valid), 0);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_done", longint'(done), 0);
    rst_n = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, Z);
    cyc(1'b0, 1'b0, 1'b0, Z);

    // Settle samples of 999 must not leak into the average
    cyc(1'b1, 1'b0, 1'b0, Z);
    feed(SETTLE, 0, 0);
    feed(N, 1, 0);
    chk("upd_busy", longint'(busy), 1);
    chk("upd_done_early", longint'(done), 0);
    cyc(1'b0, 1'b0, 1'b0, Z);
    chk("done_pulse", longint'(done), 1);
    chk("offset_100", longint'(offset), 100);
    chk("valid_after_run", longint'(offset_valid), 1);
    cyc(1'b0, 1'b0, 1'b0, Z);
    chk("done_one_cycle", longint'(done), 0);

    run(2, 0); chk("offset_alt01", longint'(offset), 1);
    run(3, 0); chk("offset_half_up", longint'(offset), 0);
    run(4, 0); chk("offset_min", longint'(offset), -8388608);
    run(5, 0); chk("offset_max", longint'(offset), 8388607);
    dc = done_cnt;
    run(6, 1); chk("offset_gapped", longint'(offset), 5);
    chk("gapped_one_done", longint'(done_cnt - dc), 1);
    repeat (3) run(7, 2);

    // Abort mid-accumulation
    run(1, 0); chk("offset_pre_abort", longint'(offset), 100);
    dc = done_cnt;
    cyc(1'b1, 1'b0, 1'b0, Z);
    feed(SETTLE, 0, 0);
    feed(50, 7, 0);
    cyc(1'b0, 1'b1, 1'b0, Z);
    chk("abort_busy", longint'(busy), 0);
    repeat (3) cyc(1'b0, 1'b0, 1'b1, W'($urandom));
    chk("abort_offset", longint'(offset), 100);
    chk("abort_no_done", longint'(done_cnt - dc), 0);

    // Abort on the UPDATE edge blocks the write
    cyc(1'b1, 1'b0, 1'b0, Z);
    feed(SETTLE, 0, 0);
    feed(N, 6, 0);
    cyc(1'b0, 1'b1, 1'b0, Z);
    chk("abort_upd_busy", longint'(busy), 0);
    cyc(1'b0, 1'b0, 1'b0, Z);
    chk("abort_upd_offset", longint'(offset), 100);
    chk("abort_upd_no_done", longint'(done_cnt - dc), 0);

    cyc(1'b1, 1'b1, 1'b0, Z);
    chk("start_abort_idle", longint'(busy), 0);

    // Reset mid-run
    cyc(1'b1, 1'b0, 1'b0, Z);
    feed(SETTLE, 0, 0);
    feed(30, 1, 0);
    rst_n = 1'b0;
    #1;
    chk("midrst_offset", longint'(offset), 0);
    chk("midrst_valid", longint'(offset_valid), 0);
    chk("midrst_busy", longint'(busy), 0);
    chk("midrst_done", longint'(done), 0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (5) cyc(1'b0, 1'b0, 1'b1, W'(100));
    chk("post_rst_idle", longint'(busy), 0);

    // Free-running random control and data
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom % 8) == 0, ($urandom % 512) == 0, ($urandom % 4) != 0, W'($urandom));
    end
    cyc(1'b0, 1'b0, 1'b0, Z);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/offset_cal_accum.md
OFFSET_CAL_ACCUM -- requirements
Module: offset_cal_accum

Interface
REQ-001: Parameter W, default 24, SHALL be the signed sample and offset width.
REQ-002: Parameter LOG2N, default 8, SHALL set the averaged sample count N = 2^LOG2N.
REQ-003: Parameter SETTLE, default 16, SHALL be the count of valid samples discarded before accumulation (0 allowed).
REQ-004: clk  input  1  SHALL be the single clock; all state updates on the rising edge.
REQ-005: rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-006: start  input  1  SHALL request a calibration run (level sampled each cycle).
REQ-007: abort  input  1  SHALL cancel a run in progress.
REQ-008: in_valid  input  1  SHALL qualify din; a sample is accepted on an edge where in_valid=1.
REQ-009: din  input  W  SHALL be the signed raw sample with the input shorted (zero-signal condition).
REQ-010: offset  output  W  SHALL be the signed registered offset estimate that drives the downstream offset-removal/gain stage.
REQ-011: offset_valid  output  1  SHALL be high once any run has completed since reset.
REQ-012: busy  output  1  SHALL be high in SETTLE, ACCUM and UPDATE.
REQ-013: done  output  1  SHALL be a one-cycle registered pulse marking an offset update.

Function
REQ-014: The FSM SHALL have states IDLE, SETTLE, ACCUM and UPDATE.
REQ-015: IDLE with start=1 SHALL clear the accumulator and sample counter and go to SETTLE, or to ACCUM directly if SETTLE=0.
REQ-016: SETTLE SHALL count accepted samples without accumulating them.
- The edge accepting the SETTLE-th sample SHALL enter ACCUM with the counter cleared.
REQ-017: ACCUM SHALL add each accepted din, sign-extended, into a signed accumulator of W+LOG2N bits; overflow is impossible by construction.
REQ-018: The edge accepting the N-th sample in ACCUM SHALL enter UPDATE.
REQ-019: Cycles with in_valid=0 SHALL hold the counter and accumulator unchanged; there is no timeout.
REQ-020: In UPDATE, the next edge SHALL:
- load offset with (acc + 2^(LOG2N-1)) >>> LOG2N, truncated to W bits (arithmetic shift, round half toward +inf; result always in W range);
- set offset_valid=1;
- assert done for exactly that following cycle;
- return to IDLE.
REQ-021: Latency SHALL be exactly one clock from the edge accepting the last sample to the edge updating offset.
REQ-022: Samples presented while in UPDATE or IDLE SHALL be ignored.
REQ-023: start SHALL be ignored while busy=1.
REQ-024: abort=1 in SETTLE, ACCUM or UPDATE SHALL return to IDLE on the next edge.
- offset, offset_valid and done SHALL be unchanged by an abort.
- abort SHALL take priority over sample acceptance and the UPDATE write on the same edge.
REQ-025: abort=1 and start=1 together in IDLE SHALL leave the FSM in IDLE.
REQ-026: offset SHALL hold its value between runs; a new run SHALL NOT disturb offset until its UPDATE edge.

Reset
REQ-027: rst_n=0 SHALL immediately force:
- state IDLE;
- accumulator and counter 0;
- offset 0, offset_valid 0, busy 0, done 0.
REQ-028: Reset asserted mid-run SHALL discard the run.
- After release, the FSM SHALL stay in IDLE until a new start.

Verification
REQ-029: Defaults, start, 16 samples of 999 then 256 samples of din=100 with no gaps -> offset=100; done high for one cycle one clock after the 256th sample; offset_valid=1.
REQ-030: 256 samples alternating 0,1 (sum 128) -> offset=1; 128 samples of -1 plus 128 samples of 0 (sum -128) -> offset=0 (half rounds up).
REQ-031: 256 samples of -8388608 -> offset=-8388608; 256 samples of 8388607 -> offset=8388607; no wrap in either case.
REQ-032: din=5 with in_valid toggling every other cycle -> offset=5 after exactly 272 accepted samples; start pulses while busy have no effect.
REQ-033: After a completed run leaving offset=100, start a new run and abort after 50 ACCUM samples -> offset stays 100 and done stays 0; rst_n pulsed mid-run -> all outputs 0 and FSM IDLE.
